rs_alu: RTL and testbench

- ALU reservation station between the dispatch stage and the ALU execute unit.
- Accepts renamed ALU micro-ops from dispatch and holds them until both source operands are ready.
- Captures operand values from the common data bus (CDB) and issues one ready op per cycle to the ALU.
- Produces the `rsalu_full` status consumed by the hazard unit's stall logic; flushed entirely by `rollback` on mispredict.

---
 rtl/rs_alu_pkg.sv | 33 +++
 rtl/rs_alu_if.sv | 57 +++++
 rtl/rs_alu_select.sv | 33 +++
 rtl/rs_alu.sv | 173 +++++++++++++++++
 tb/tb_rs_alu.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// rs_alu shared constants: FU encoding, ALU opcodes, default sizes.
// Issue bundle type used by consumers of the ALU issue port.
package rs_alu_pkg;

  localparam int RS_ALU_DEPTH = 8;
  localparam int RS_XLEN      = 32;
  localparam int RS_TAG_W     = 5;
  localparam int RS_OP_W      = 4;

  localparam logic [2:0] FU_ALU = 3'd0;

  typedef enum logic [RS_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] rob_tag;
    logic [RS_XLEN-1:0]  src1;
    logic [RS_XLEN-1:0]  src2;
  } rs_iss_t;

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch, CDB, rollback and ALU issue bundle of the ALU reservation station.
// master = dispatch/hazard/ALU side, slave = reservation station.
interface rs_alu_if
  import rs_alu_pkg::*;
#(
  parameter int XLEN  = RS_XLEN,
  parameter int TAG_W = RS_TAG_W,
  parameter int OP_W  = RS_OP_W,
  parameter int CNT_W = $clog2(RS_ALU_DEPTH) + 1
);
  logic             disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_rob_tag;
  logic             disp_src1_rdy;
  logic             disp_src2_rdy;
  logic [TAG_W-1:0] disp_src1_tag;
  logic [TAG_W-1:0] disp_src2_tag;
  logic [XLEN-1:0]  disp_src1_val;
  logic [XLEN-1:0]  disp_src2_val;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_val;
  logic             rollback;
  logic             issue_ready;
  logic             issue_valid;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_rob_tag;
  logic [XLEN-1:0]  issue_src1;
  logic [XLEN-1:0]  issue_src2;
  logic             rsalu_full;
  logic [CNT_W-1:0] rs_count;

  modport master (
    output disp_valid, disp_op, disp_rob_tag,
    output disp_src1_rdy, disp_src2_rdy,
    output disp_src1_tag, disp_src2_tag,
    output disp_src1_val, disp_src2_val,
    output cdb_valid, cdb_tag, cdb_val,
    output rollback, issue_ready,
    input  issue_valid, issue_op, issue_rob_tag,
    input  issue_src1, issue_src2,
    input  rsalu_full, rs_count
  );

  modport slave (
    input  disp_valid, disp_op, disp_rob_tag,
    input  disp_src1_rdy, disp_src2_rdy,
    input  disp_src1_tag, disp_src2_tag,
    input  disp_src1_val, disp_src2_val,
    input  cdb_valid, cdb_tag, cdb_val,
    input  rollback, issue_ready,
    output issue_valid, issue_op, issue_rob_tag,
    output issue_src1, issue_src2,
    output rsalu_full, rs_count
  );

endinterface

// File: rtl/rs_alu_select.sv
// One-hot grant over a request vector: lowest index, or oldest by age matrix
// when RSALU_OLDEST_FIRST_EN is defined (all-zero matrix gives lowest index).
module rs_alu_select #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
`ifdef RSALU_OLDEST_FIRST_EN
  input  logic [N-1:0][N-1:0]  age_i,
`endif
  output logic [N-1:0]         gnt_o,
  output logic                 vld_o
);

`ifdef RSALU_OLDEST_FIRST_EN
  // i beats j if marked older, or on an unordered pair, if lower index
  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] &&
            !(age_i[i][j] || (!age_i[j][i] && i < j)))
          gnt_o[i] = 1'b0;
      end
    end
  end
`else
  assign gnt_o = req_i & (~req_i + N'(1));
`endif

  assign vld_o = |req_i;

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: operand capture from CDB, one issue per cycle.
// RSALU_OLDEST_FIRST_EN selects oldest-eligible issue via an age matrix.
module rs_alu
  import rs_alu_pkg::*;
#(
  parameter int DEPTH = RS_ALU_DEPTH,
  parameter int XLEN  = RS_XLEN,
  parameter int TAG_W = RS_TAG_W,
  parameter int OP_W  = RS_OP_W
) (
  input logic  clk,
  input logic  rst_n,
  rs_alu_if.slave rs
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] s1_rdy_q, s2_rdy_q;
  logic [OP_W-1:0]  op_q     [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] s1_tag_q [DEPTH];
  logic [TAG_W-1:0] s2_tag_q [DEPTH];
  logic [XLEN-1:0]  s1_val_q [DEPTH];
  logic [XLEN-1:0]  s2_val_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q;

  logic [DEPTH-1:0] elig, iss_gnt, alloc_gnt;
  logic             iss_any, free_any;
  logic             alloc, fire;
  logic             cap1, cap2;
  logic [XLEN-1:0]  cval1, cval2;
  logic [OP_W-1:0]  iss_op;
  logic [TAG_W-1:0] iss_tag;
  logic [XLEN-1:0]  iss_s1, iss_s2;

  assign elig = valid_q & s1_rdy_q & s2_rdy_q;

`ifdef RSALU_OLDEST_FIRST_EN
  logic [DEPTH-1:0][DEPTH-1:0] age_q;

  rs_alu_select #(.N(DEPTH)) u_iss (
    .req_i (elig),
    .age_i (age_q),
    .gnt_o (iss_gnt),
    .vld_o (iss_any)
  );

  rs_alu_select #(.N(DEPTH)) u_alloc (
    .req_i (~valid_q),
    .age_i ('0),
    .gnt_o (alloc_gnt),
    .vld_o (free_any)
  );

  // age_q[i][j]: entry i was allocated before entry j
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q <= '0;
    end else if (alloc) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (alloc_gnt[i])
            age_q[i][j] <= 1'b0;
          else if (alloc_gnt[j])
            age_q[i][j] <= 1'b1;
    end
  end
`else
  rs_alu_select #(.N(DEPTH)) u_iss (
    .req_i (elig),
    .gnt_o (iss_gnt),
    .vld_o (iss_any)
  );

  rs_alu_select #(.N(DEPTH)) u_alloc (
    .req_i (~valid_q),
    .gnt_o (alloc_gnt),
    .vld_o (free_any)
  );
`endif

  assign alloc = rs.disp_valid & ~full_q & ~rs.rollback & free_any;
  assign fire  = rs.issue_valid & rs.issue_ready;

  assign cap1  = rs.disp_src1_rdy |
                 (rs.cdb_valid && rs.cdb_tag == rs.disp_src1_tag);
  assign cap2  = rs.disp_src2_rdy |
                 (rs.cdb_valid && rs.cdb_tag == rs.disp_src2_tag);
  assign cval1 = rs.disp_src1_rdy ? rs.disp_src1_val : rs.cdb_val;
  assign cval2 = rs.disp_src2_rdy ? rs.disp_src2_val : rs.cdb_val;

  always_comb begin
    iss_op  = '0;
    iss_tag = '0;
    iss_s1  = '0;
    iss_s2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_gnt[i]) begin
        iss_op  = op_q[i];
        iss_tag = tag_q[i];
        iss_s1  = s1_val_q[i];
        iss_s2  = s2_val_q[i];
      end
    end
  end

  assign rs.issue_valid   = iss_any & ~rs.rollback;
  assign rs.issue_op      = iss_op;
  assign rs.issue_rob_tag = iss_tag;
  assign rs.issue_src1    = iss_s1;
  assign rs.issue_src2    = iss_s2;
  assign rs.rsalu_full    = full_q;
  assign rs.rs_count      = cnt_q;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q + CW'(alloc) - CW'(fire);
    if (fire)
      valid_d = valid_d & ~iss_gnt;
    if (alloc)
      valid_d = valid_d | alloc_gnt;
    if (rs.rollback) begin
      valid_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        tag_q[i]    <= '0;
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && alloc_gnt[i]) begin
          op_q[i]     <= rs.disp_op;
          tag_q[i]    <= rs.disp_rob_tag;
          s1_rdy_q[i] <= cap1;
          s2_rdy_q[i] <= cap2;
          s1_tag_q[i] <= rs.disp_src1_tag;
          s2_tag_q[i] <= rs.disp_src2_tag;
          s1_val_q[i] <= cval1;
          s2_val_q[i] <= cval2;
        end else if (valid_q[i] && rs.cdb_valid) begin
          if (!s1_rdy_q[i] && s1_tag_q[i] == rs.cdb_tag) begin
            s1_rdy_q[i] <= 1'b1;
            s1_val_q[i] <= rs.cdb_val;
          end
          if (!s2_rdy_q[i] && s2_tag_q[i] == rs.cdb_tag) begin
            s2_rdy_q[i] <= 1'b1;
            s2_val_q[i] <= rs.cdb_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed scenarios plus random traffic
// against a slot-level reference model.
module tb_rs_alu;
  import rs_alu_pkg::*;

  localparam int D = RS_ALU_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_alu_if bus ();

  rs_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (bus)
  );

  logic        d_valid, d_r1, d_r2, c_valid, rb, ir;
  logic [3:0]  d_op;
  logic [4:0]  d_tag, d_t1, d_t2, c_tag;
  logic [31:0] d_v1, d_v2, c_val;
  bit          allow_full;

  int n_cmp = 0;
  int n_bad = 0;
  rs_iss_t exp_q[$];

  bit          m_v  [D];
  logic [3:0]  m_op [D];
  logic [4:0]  m_tag[D];
  bit          m_r1 [D];
  bit          m_r2 [D];
  logic [4:0]  m_t1 [D];
  logic [4:0]  m_t2 [D];
  logic [31:0] m_s1 [D];
  logic [31:0] m_s2 [D];
  int          m_seq[D];
  int          seq_ctr = 0;
  int          m_cnt = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick_issue();
    int best = -1;
    for (int i = 0; i < D; i++) begin
      if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef RSALU_OLDEST_FIRST_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic int pick_free();
    for (int i = 0; i < D; i++)
      if (!m_v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) m_v[i] = 0;
    m_cnt = 0;
  endtask

  task automatic idle();
    d_valid = 0; d_op = 0; d_tag = 0;
    d_r1 = 1; d_t1 = 0; d_v1 = 0;
    d_r2 = 1; d_t2 = 0; d_v2 = 0;
    c_valid = 0; c_tag = 0; c_val = 0;
    rb = 0;
  endtask

  task automatic drive();
    bus.disp_valid    = d_valid;
    bus.disp_op       = d_op;
    bus.disp_rob_tag  = d_tag;
    bus.disp_src1_rdy = d_r1;
    bus.disp_src1_tag = d_t1;
    bus.disp_src1_val = d_v1;
    bus.disp_src2_rdy = d_r2;
    bus.disp_src2_tag = d_t2;
    bus.disp_src2_val = d_v2;
    bus.cdb_valid     = c_valid;
    bus.cdb_tag       = c_tag;
    bus.cdb_val       = c_val;
    bus.rollback      = rb;
    bus.issue_ready   = ir;
  endtask

  // one cycle: drive at negedge, check against model, advance model
  task automatic step();
    int  sel, fr;
    bit  exp_iv, alloc;
    rs_iss_t e;
    @(negedge clk);
    drive();
    #1;
    assert (!(bus.disp_valid && bus.rsalu_full) || allow_full)
      else $error("dispatch while full at %0t", $time);
    sel    = pick_issue();
    exp_iv = (sel >= 0) && !rb;
    check("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
    check("rs_count", 64'(bus.rs_count), 64'(m_cnt));
    check("rsalu_full", 64'(bus.rsalu_full), 64'(m_cnt == D));
    if (exp_iv && ir) begin
      e.op = m_op[sel]; e.rob_tag = m_tag[sel];
      e.src1 = m_s1[sel]; e.src2 = m_s2[sel];
      exp_q.push_back(e);
    end
    fr    = pick_free();
    alloc = d_valid && m_cnt < D && !rb;
    if (rb) begin
      model_clear();
    end else begin
      for (int i = 0; i < D; i++) begin
        if (m_v[i] && c_valid) begin
          if (!m_r1[i] && m_t1[i] == c_tag) begin m_r1[i] = 1; m_s1[i] = c_val; end
          if (!m_r2[i] && m_t2[i] == c_tag) begin m_r2[i] = 1; m_s2[i] = c_val; end
        end
      end
      if (exp_iv && ir) begin
        m_v[sel] = 0;
        m_cnt--;
      end
      if (alloc) begin
        m_v[fr] = 1; m_op[fr] = d_op; m_tag[fr] = d_tag;
        m_t1[fr] = d_t1; m_t2[fr] = d_t2;
        m_r1[fr] = d_r1 || (c_valid && c_tag == d_t1);
        m_r2[fr] = d_r2 || (c_valid && c_tag == d_t2);
        m_s1[fr] = d_r1 ? d_v1 : c_val;
        m_s2[fr] = d_r2 ? d_v2 : c_val;
        m_seq[fr] = seq_ctr++;
        m_cnt++;
      end
    end
  endtask

  task automatic disp(logic [3:0] op, logic [4:0] tag,
                      logic r1, logic [4:0] t1, logic [31:0] v1,
                      logic r2, logic [4:0] t2, logic [31:0] v2);
    d_valid = 1; d_op = op; d_tag = tag;
    d_r1 = r1; d_t1 = t1; d_v1 = v1;
    d_r2 = r2; d_t2 = t2; d_v2 = v2;
  endtask

  task automatic drain();
    idle();
    ir = 1;
    for (int k = 0; k < 2 * D && m_cnt > 0; k++) step();
    check("drained", 64'(m_cnt), 64'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_count", 64'(bus.rs_count), 64'd0);
    check("rst_ivalid", 64'(bus.issue_valid), 64'd0);
    check("rst_full", 64'(bus.rsalu_full), 64'd0);
    check("rst_src1", 64'(bus.issue_src1), 64'd0);
    model_clear();
    #1 rst_n = 1;
  endtask

  // monitor: pop and compare on every issue handshake
  initial begin
    rs_iss_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.issue_valid && bus.issue_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_unexpected: got tag %0h expected none at %0t",
                   bus.issue_rob_tag, $time);
        end else begin
          e = exp_q.pop_front();
          check("issue_op", 64'(bus.issue_op), 64'(e.op));
          check("issue_tag", 64'(bus.issue_rob_tag), 64'(e.rob_tag));
          check("issue_src1", 64'(bus.issue_src1), 64'(e.src1));
          check("issue_src2", 64'(bus.issue_src2), 64'(e.src2));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    allow_full = 0;
    ir = 0;
    idle();
    drive();
    #3;
    check("reset_ivalid", 64'(bus.issue_valid), 64'd0);
    check("reset_count", 64'(bus.rs_count), 64'd0);
    check("reset_full", 64'(bus.rsalu_full), 64'd0);
    check("reset_src1", 64'(bus.issue_src1), 64'd0);
    check("reset_src2", 64'(bus.issue_src2), 64'd0);
    #9 rst_n = 1;

    // basic issue
    ir = 1;
    disp(ALU_ADD, 5'd3, 1, 0, 32'd5, 1, 0, 32'd7);
    step();
    idle();
    step();
    check("t1_src1", 64'(bus.issue_src1), 64'd5);
    check("t1_tag", 64'(bus.issue_rob_tag), 64'd3);
    step();

    // CDB wakeup
    disp(ALU_SUB, 5'd1, 0, 5'd9, 32'd0, 1, 0, 32'd1);
    step();
    idle();
    step();
    step();
    c_valid = 1; c_tag = 5'd9; c_val = 32'h55;
    step();
    idle();
    step();
    check("t2_src1", 64'(bus.issue_src1), 64'h55);
    step();

    // dispatch-cycle capture
    disp(ALU_OR, 5'd2, 1, 0, 32'd9, 0, 5'd4, 32'd0);
    c_valid = 1; c_tag = 5'd4; c_val = 32'hAA;
    step();
    idle();
    step();
    check("t3_src2", 64'(bus.issue_src2), 64'hAA);
    step();

    // fill to full, 9th dispatch ignored
    ir = 0;
    for (int k = 0; k < D; k++) begin
      disp(ALU_XOR, 5'(k + 8), 1, 0, 32'(k), 1, 0, 32'(k * 3));
      step();
    end
    allow_full = 1;
    disp(ALU_AND, 5'd30, 1, 0, 32'd1, 1, 0, 32'd1);
    step();
    allow_full = 0;
    idle();
    ir = 1;
    step();
    ir = 0;
    step();
    check("t4_count", 64'(bus.rs_count), 64'd7);
    drain();

    // rollback with concurrent dispatch and ready
    ir = 0;
    for (int k = 0; k < 5; k++) begin
      disp(ALU_SLL, 5'(k), k[0], 5'd20, 32'(k), 1, 0, 32'd2);
      step();
    end
    disp(ALU_SRL, 5'd25, 1, 0, 32'd1, 1, 0, 32'd1);
    rb = 1; ir = 1;
    step();
    idle();
    step();
    check("t5_ivalid", 64'(bus.issue_valid), 64'd0);
    check("t5_count", 64'(bus.rs_count), 64'd0);

    // age ordering: A waits, B ready, A issues, C refills slot 0
    ir = 0;
    disp(ALU_ADD, 5'd10, 0, 5'd20, 32'd0, 1, 0, 32'd1);
    step();
    disp(ALU_ADD, 5'd11, 1, 0, 32'd2, 1, 0, 32'd3);
    step();
    idle();
    c_valid = 1; c_tag = 5'd20; c_val = 32'h77;
    step();
    idle();
    step();
    ir = 1;
    step();
    ir = 0;
    disp(ALU_ADD, 5'd12, 1, 0, 32'd4, 1, 0, 32'd5);
    step();
    idle();
    step();
`ifdef RSALU_OLDEST_FIRST_EN
    check("t6_first", 64'(bus.issue_rob_tag), 64'd11);
`else
    check("t6_first", 64'(bus.issue_rob_tag), 64'd12);
`endif
    drain();

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) mid_reset();
      idle();
      if ($urandom_range(1) == 1 && m_cnt < D)
        disp(4'($urandom_range(10)), 5'($urandom_range(31)),
             1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
             1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
      c_valid = 1'($urandom_range(1));
      c_tag   = 5'($urandom_range(7));
      c_val   = $urandom;
      rb      = ($urandom_range(49) == 0);
      if (((cyc / 200) % 2) == 0)
        ir = ($urandom_range(3) != 0);
      else
        ir = ($urandom_range(3) == 0);
      step();
    end
    idle();
    rb = 1;
    step();
    idle();
    step();
    @(negedge clk);
    #3;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
